alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
- Issue stage directly upstream of the 32-bit ALU in the RISC-V PE.
- Accepts one decoded RV32I OP/OP-IMM instruction (plus MUL/DIVU) per handshake and translates opcode/funct3/funct7 into the 5-bit ALU select code.
- Registers the ALU operands, waits out the ALU's registered latency, then captures the result.
- Presents the result with its own zero flag and destination register on a valid/ready output to writeback.

Parameters:
- ALU_LAT, 1, clocks between operands appearing on alu_a/alu_b/alu_sel and alu_out being valid (range 1-15).
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept an instruction
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- rs1_val  in  32  source register 1 value
- rs2_val  in  32  source register 2 value
- imm  in  32  sign-extended I-immediate
- rd  in  5  destination register
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_sel  out  5  ALU select code
- alu_out  in  32  ALU registered result
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  32  captured result
- out_zero  out  1  out_result == 0
- out_rd  out  5  destination register of the result
- out_illegal  out  1  encoding not supported
- busy  out  1  state != IDLE

Behaviour:
- Reset: on rst=1 at a rising edge, state=IDLE and all registered outputs are 0; in_ready=1 the following cycle. Reset mid-operation aborts silently, and the in-flight result is discarded.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, register alu_a/alu_b/alu_sel/rd, load cnt=ALU_LAT, go to EXEC. If the encoding is illegal, instead set out_illegal=1, out_result=0, out_zero=1, go to DONE.
  - EXEC: each edge with cnt!=0 decrements cnt. At the edge where cnt==0: out_result<=alu_out, out_zero<=(alu_out==0), out_illegal<=0, go to DONE.
  - DONE: out_valid=1. out_result, out_zero, out_rd and out_illegal stay stable until out_ready. On out_valid & out_ready, go to IDLE.
- Latency, accept edge to out_valid high: ALU_LAT+1 clocks (2 by default); illegal encodings take 1 clock.
- alu_a/alu_b/alu_sel hold their values from accept until the next accept; they are not cleared on return to IDLE.
- Operand mapping: alu_a=rs1_val. For opcode 0110011, alu_b=rs2_val. For 0010011, alu_b=imm.
- Shift masking: for every shift, alu_b is masked to {27'b0, src[4:0]}.
- Decode for opcode 0110011 (funct7/funct3 -> alu_sel):
  - 0000000: 000->0 ADD, 001->4 SLL, 010->14 SLT, 011->13 SLTU, 100->10 XOR, 101->5 SRL, 110->9 OR, 111->8 AND.
  - 0100000: 000->1 SUB, 101->15 SRA.
  - 0000001: 000->2 MUL, 101->3 DIVU.
- Decode for opcode 0010011 (funct3 -> alu_sel):
  - 000->0, 010->14, 011->13, 100->10, 110->9, 111->8.
  - 001 requires funct7=0000000 -> 4.
  - 101 requires funct7=0000000 -> 5, or funct7=0100000 -> 15.
- Everything else is illegal, including other opcodes, other M-extension ops and other funct7 values.
- DIVU by zero returns the ALU's 0xFFFFFFFF unchanged.
- out_zero is computed inside this block; the ALU's Zero and ALUcomplete outputs are not used.
- in_valid is ignored when in_ready=0. Input fields are sampled only on the accept edge.
- Simultaneous rst and handshake: reset wins.

Optional Feature:
- Macro: ALU_DISPATCH_BACK2BACK_EN.
- Defined: in_ready = (state==IDLE) | (state==DONE & out_ready). A handshake in DONE completes the output transfer and accepts the new instruction on the same edge (going to EXEC, or to DONE if illegal), so there is no idle bubble.
- Undefined: in_ready = (state==IDLE) only, which gives one bubble cycle between instructions.

Test Plan:
- ADD: rs1=5, rs2=7, funct7=0, funct3=000, opcode 0110011 -> alu_sel=0; out_result=12, out_zero=0 at 2 clocks after accept.
- SUB to zero: rs1=rs2=0x1234 -> out_result=0, out_zero=1. Then SRAI imm=0x40000404, rs1=0x80000000 -> alu_b=4, alu_sel=15, out_result=0xF8000000.
- Illegal: funct7=0000001, funct3=100 (DIV) -> out_valid 1 clock after accept, out_illegal=1, out_result=0.
- Backpressure: out_ready held 0 for 5 cycles after DIVU 100/7 -> out_result=14 stable and in_ready=0 throughout; with the macro undefined, accept resumes 1 cycle after out_ready.
- Reset mid-EXEC: assert rst one cycle after accept -> out_valid never rises, in_ready=1 the next cycle, all registered outputs 0.
- ALU_DISPATCH_BACK2BACK_EN with out_ready=1 and two back-to-back ORs (0xF0|0x0F, then 0x1|0x2) -> results 0xFF then 0x3 with out_valid 3 clocks apart.

Source files
------------

// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage in front of the 32-bit ALU of the RISC-V PE.
// Decodes RV32I OP/OP-IMM (plus MUL/DIVU) into an ALU select code, registers
// the operands, waits out the ALU latency and hands the captured result to
// writeback over a valid/ready interface.
// Optional: define ALU_DISPATCH_BACK2BACK_EN to accept a new instruction on
// the same edge that the pending result is handed off (no idle bubble).
module alu_dispatch #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_sel,
    input  logic [XLEN-1:0] alu_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic            busy
);

    localparam logic [6:0] OpReg  = 7'b0110011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mext = 7'b0000001;
    localparam logic [3:0] LatCnt = 4'(ALU_LAT);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [4:0]        sel_q, sel_d, rd_q, rd_d;
    logic              zero_q, zero_d, ill_q, ill_d;

    logic              legal, is_shift, accept;
    logic [4:0]        sel_dec;
    logic [XLEN-1:0]   b_src, b_dec;

    // Translate opcode/funct3/funct7 into the ALU select code and legality.
    always_comb begin
        legal    = 1'b0;
        sel_dec  = 5'd0;
        is_shift = 1'b0;
        case (opcode)
            OpReg: begin
                case (funct7)
                    F7Base: begin
                        legal = 1'b1;
                        case (funct3)
                            3'b000: sel_dec = 5'd0;
                            3'b001: begin sel_dec = 5'd4; is_shift = 1'b1; end
                            3'b010: sel_dec = 5'd14;
                            3'b011: sel_dec = 5'd13;
                            3'b100: sel_dec = 5'd10;
                            3'b101: begin sel_dec = 5'd5; is_shift = 1'b1; end
                            3'b110: sel_dec = 5'd9;
                            3'b111: sel_dec = 5'd8;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7Alt: begin
                        if (funct3 == 3'b000) begin
                            legal   = 1'b1;
                            sel_dec = 5'd1;
                        end else if (funct3 == 3'b101) begin
                            legal    = 1'b1;
                            sel_dec  = 5'd15;
                            is_shift = 1'b1;
                        end
                    end
                    F7Mext: begin
                        if (funct3 == 3'b000) begin
                            legal   = 1'b1;
                            sel_dec = 5'd2;
                        end else if (funct3 == 3'b101) begin
                            legal   = 1'b1;
                            sel_dec = 5'd3;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OpImm: begin
                legal = 1'b1;
                case (funct3)
                    3'b000: sel_dec = 5'd0;
                    3'b010: sel_dec = 5'd14;
                    3'b011: sel_dec = 5'd13;
                    3'b100: sel_dec = 5'd10;
                    3'b110: sel_dec = 5'd9;
                    3'b111: sel_dec = 5'd8;
                    3'b001: begin
                        legal    = (funct7 == F7Base);
                        sel_dec  = 5'd4;
                        is_shift = 1'b1;
                    end
                    3'b101: begin
                        legal    = (funct7 == F7Base) || (funct7 == F7Alt);
                        sel_dec  = (funct7 == F7Alt) ? 5'd15 : 5'd5;
                        is_shift = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Operand B source; shift amounts are limited to 5 bits.
    assign b_src = (opcode == OpImm) ? imm : rs2_val;
    assign b_dec = is_shift ? {{(XLEN-5){1'b0}}, b_src[4:0]} : b_src;

`ifdef ALU_DISPATCH_BACK2BACK_EN
    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
`else
    assign in_ready = (state_q == StIdle);
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

    // Next-state logic: sequencing plus capture of operands and results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        unique case (state_q)
            StIdle: ;
            StExec: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = alu_out;
                    zero_d  = (alu_out == '0);
                    ill_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Accept overrides the DONE->IDLE hand-off when back-to-back is enabled.
        if (accept) begin
            rd_d = rd;
            if (legal) begin
                a_d     = rs1_val;
                b_d     = b_dec;
                sel_d   = sel_dec;
                cnt_d   = LatCnt;
                state_d = StExec;
            end else begin
                ill_d   = 1'b1;
                res_d   = '0;
                zero_d  = 1'b1;
                state_d = StDone;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 5'd0;
            rd_q    <= 5'd0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_sel     = sel_q;
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_rd      = rd_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: stimulus pushes hand-computed expected
// results, a monitor pops and compares on every output handshake.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_sel;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        busy;

    alu_dispatch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered ALU with one clock of latency.
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [4:0] s);
        case (s)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a * b;
            5'd3:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd4:  return a << b[4:0];
            5'd5:  return a >> b[4:0];
            5'd8:  return a & b;
            5'd9:  return a | b;
            5'd10: return a ^ b;
            5'd13: return {31'd0, a < b};
            5'd14: return {31'd0, $signed(a) < $signed(b)};
            5'd15: return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int hs_prev = 0;
    int hs_last = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every negedge with valid & ready is one transfer at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                hs_prev = hs_last;
                hs_last = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_output", {27'd0, out_rd}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
                    chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                    if (!e.ill) chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                end
            end
        end
    end

    // Offer one instruction, wait (bounded) for the accept edge, return at edge+1.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] r, input logic [31:0] res, input logic ill,
                         input bit push);
        int n = 0;
        exp_t e;
        if (push) begin
            e.res = res; e.zero = (res == 32'd0); e.rd = r; e.ill = ill;
            sb.push_back(e);
        end
        opcode = op; funct3 = f3; funct7 = f7;
        rs1_val = a; rs2_val = b; imm = im; rd = r;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int n;
        vecs[0]  = '{R, 3'b100, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'd11, 32'hF0F0F0F0, 1'b0};
        vecs[1]  = '{R, 3'b011, 7'h00, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd12, 32'h1, 1'b0};
        vecs[2]  = '{I, 3'b010, 7'h00, 32'hFFFFFFFE, 32'h0, 32'h1, 5'd13, 32'h1, 1'b0};
        vecs[3]  = '{I, 3'b000, 7'h7F, 32'd10, 32'h0, 32'hFFFFFFF6, 5'd14, 32'h0, 1'b0};
        vecs[4]  = '{R, 3'b001, 7'h00, 32'h1, 32'h23, 32'h0, 5'd15, 32'h8, 1'b0};
        vecs[5]  = '{I, 3'b101, 7'h00, 32'h80000000, 32'h0, 32'h1F, 5'd16, 32'h1, 1'b0};
        vecs[6]  = '{R, 3'b000, 7'h01, 32'd6, 32'd7, 32'h0, 5'd17, 32'd42, 1'b0};
        vecs[7]  = '{R, 3'b101, 7'h01, 32'd5, 32'd0, 32'h0, 5'd18, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{I, 3'b001, 7'h01, 32'd1, 32'h0, 32'h21, 5'd19, 32'h0, 1'b1};
        vecs[9]  = '{7'b0000011, 3'b010, 7'h00, 32'd1, 32'd2, 32'h0, 5'd20, 32'h0, 1'b1};
        vecs[10] = '{R, 3'b001, 7'h20, 32'd1, 32'd2, 32'h0, 5'd21, 32'h0, 1'b1};
        vecs[11] = '{I, 3'b111, 7'h00, 32'h12345678, 32'h0, 32'h0000FFFF, 5'd22, 32'h5678, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_alu_sel", {27'd0, alu_sel}, 32'd0);

        // ADD with latency check
        issue(R, 3'b000, 7'h00, 32'd5, 32'd7, 32'h0, 5'd3, 32'd12, 1'b0, 1'b1);
        chk("add_alu_sel", {27'd0, alu_sel}, 32'd0);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("add_valid_lat1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("add_valid_lat2", {31'd0, out_valid}, 32'd1);

        // SUB to zero, then SRAI with masked shift amount
        issue(R, 3'b000, 7'h20, 32'h1234, 32'h1234, 32'h0, 5'd4, 32'd0, 1'b0, 1'b1);
        issue(I, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'h40000404, 5'd5, 32'hF8000000,
              1'b0, 1'b1);
        chk("srai_alu_b", alu_b, 32'd4);
        chk("srai_alu_sel", {27'd0, alu_sel}, 32'd15);

        // Illegal DIV: result one clock after accept
        issue(R, 3'b100, 7'h01, 32'd9, 32'd3, 32'h0, 5'd6, 32'd0, 1'b1, 1'b1);
        chk("ill_valid_lat", {31'd0, out_valid}, 32'd1);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);

        // Backpressure on DIVU 100/7
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(R, 3'b101, 7'h01, 32'd100, 32'd7, 32'h0, 5'd7, 32'd14, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", out_result, 32'd14);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
`ifdef ALU_DISPATCH_BACK2BACK_EN
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
`else
        chk("bp_release_ready", {31'd0, in_ready}, 32'd0);
`endif
        @(posedge clk); #1;
        chk("bp_after_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_after_valid", {31'd0, out_valid}, 32'd0);

        // Reset one cycle after accept: result discarded
        issue(R, 3'b000, 7'h00, 32'd3, 32'd4, 32'h0, 5'd10, 32'd7, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_sel", {27'd0, alu_sel}, 32'd0);
        chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
        chk("mid_rst_zero", {31'd0, out_zero}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end

        // Two ORs in a row: handshake spacing shows whether a bubble exists
        issue(R, 3'b110, 7'h00, 32'hF0, 32'h0F, 32'h0, 5'd8, 32'hFF, 1'b0, 1'b1);
        issue(R, 3'b110, 7'h00, 32'h1, 32'h2, 32'h0, 5'd9, 32'h3, 1'b0, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
`ifdef ALU_DISPATCH_BACK2BACK_EN
        chk("or_spacing", hs_last - hs_prev, 32'd3);
`else
        chk("or_spacing", hs_last - hs_prev, 32'd4);
`endif

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].im,
                  vecs[i].rd, vecs[i].res, vecs[i].ill, 1'b1);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
